exu_muldiv: RTL and testbench
=============================

Name: exu_muldiv

Overview:
- Multi-cycle RV64M execution unit that sits beside the single-cycle ALU in the execute stage.
- The execute stage routes mul/div micro-ops here. The unit computes iteratively and holds the pipeline through a stall request until its result is consumed.
- Generalised in XLEN and multiplier radix, and supports the 32-bit W variants.

Parameters:
- XLEN, 64, datapath width (32 or 64; with 32, W ops are illegal and treated as non-W).
- MUL_STEP, 2, multiplier bits retired per CALC cycle (1, 2 or 4; must divide 32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  kill the in-flight op (trap/branch redirect)
- valid_i  in  1  op presented
- ready_o  out  1  unit can accept (state==IDLE)
- muldiv_op_i  in  `MULOP_LEN  operation code
- word_i  in  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- rs1_data_i  in  XLEN  operand a
- rs2_data_i  in  XLEN  operand b
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream takes result
- result_o  out  XLEN  result
- stall_req_o  out  1  request pipeline hold

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). On reset: state=IDLE, out_valid_o=0, result_o=0, all internal registers 0. ready_o=1 after reset.
- Accept: when valid_i & ready_o & !flush_i, latch op, word, and the prepared operands.
- Operand preparation:
  - W ops: take bits [31:0]; sign-extend for signed ops, zero-extend for unsigned; operation width opw=32, otherwise opw=XLEN.
  - Signed ops convert operands to magnitudes and record the result sign.
  - MULHSU: a signed, b unsigned.
- FSM states:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept via the fast path for divide-by-zero and signed overflow.
  - CALC -> DONE when the iteration counter reaches terminal count.
  - DONE -> IDLE on out_ready_i.
  - Any state -> IDLE on flush_i; flush beats accept in the same cycle.
- CALC length:
  - MUL*: opw/MUL_STEP cycles, shift-add over a 2*opw product.
  - DIV/REM: opw cycles, restoring division, 1 quotient bit per cycle.
  - The counter loads at accept and decrements each CALC cycle.
- Latency from accept edge to out_valid_o high:
  - MUL: opw/MUL_STEP+1 cycles.
  - DIV: opw+1 cycles.
  - Fast path: 1 cycle.
- Results:
  - MUL/MULW: low opw bits.
  - MULH/MULHSU/MULHU: high XLEN bits of the signed/mixed/unsigned product.
  - Quotient sign = sa^sb; remainder sign = sa.
  - Divide by zero: quotient = all ones, remainder = dividend (opw view).
  - Overflow (most-negative / -1, signed): quotient = dividend, remainder = 0.
  - W ops: final result sign-extended from bit 31.
- DONE holds: out_valid_o=1 and result_o stable until out_ready_i. result_o holds its last value after leaving DONE.
- Back-to-back: DONE & out_ready_i returns to IDLE. A new accept is possible the following cycle, not the same cycle.
- stall_req_o = (valid_i & state==IDLE & !flush_i) | state==CALC | (state==DONE & !out_ready_i).
- Flush:
  - Mid-CALC: out_valid_o=0 next cycle and the counter is discarded.
  - In DONE: the result is dropped.
- Reset mid-operation: identical to flush, plus result_o=0.

Decomposition:
- sysconfig.v gets:
  - `MULOP_LEN (4).
  - `MULOP_MUL, `MULOP_MULH, `MULOP_MULHSU, `MULOP_MULHU, `MULOP_DIV, `MULOP_DIVU, `MULOP_REM, `MULOP_REMU.
  - `EXCOP_MULDIV, for the execute-stage decode that raises valid_i.
- One sub-module, exu_div_core: iterative unsigned restoring divider with start, opw select, done, quotient, and remainder.
- The multiplier iteration and sign fix-up stay in exu_muldiv.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid_o exactly 33 cycles after accept (MUL_STEP=2); stall_req_o high throughout until consumed.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-20, b=3 -> -6 after 65 cycles; REM same operands -> -2; DIVU a=20, b=3 -> 6.
- DIV a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF in 1 cycle; REM -> 5; DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000, REM -> 0.
- DIVW a=0x1_8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (overflow fast path); MULW a=0x8000_0000, b=2 -> 0; REMUW a=0xFFFF_FFFF, b=0x10 -> 0xF.
- Flush asserted at CALC cycle 10 -> IDLE next cycle, out_valid_o never rises. Then out_ready_i=0 for 5 cycles during DONE -> result_o stable and stall_req_o held; rst asserted mid-CALC -> all outputs 0, ready_o=1 next cycle.

Source files
------------

// File: rtl/exu_muldiv_pkg.sv
// Shared definitions for the multi-cycle mul/div execution unit.
//   - MULOP_* operation codes carried on muldiv_op_i
//   - EXCOP_MULDIV: execute-stage op class that raises valid_i toward this unit
//   - FSM state encoding and small opcode classification helpers
package exu_muldiv_pkg;

  localparam int MULOP_LEN = 4;
  localparam int EXCOP_LEN = 4;

  localparam logic [MULOP_LEN-1:0] MULOP_MUL    = 4'd0;
  localparam logic [MULOP_LEN-1:0] MULOP_MULH   = 4'd1;
  localparam logic [MULOP_LEN-1:0] MULOP_MULHSU = 4'd2;
  localparam logic [MULOP_LEN-1:0] MULOP_MULHU  = 4'd3;
  localparam logic [MULOP_LEN-1:0] MULOP_DIV    = 4'd4;
  localparam logic [MULOP_LEN-1:0] MULOP_DIVU   = 4'd5;
  localparam logic [MULOP_LEN-1:0] MULOP_REM    = 4'd6;
  localparam logic [MULOP_LEN-1:0] MULOP_REMU   = 4'd7;

  localparam logic [EXCOP_LEN-1:0] EXCOP_MULDIV = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [MULOP_LEN-1:0] op);
    return (op == MULOP_DIV) || (op == MULOP_DIVU) || (op == MULOP_REM) || (op == MULOP_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [MULOP_LEN-1:0] op);
    return (op == MULOP_REM) || (op == MULOP_REMU);
  endfunction

  function automatic logic op_signed_a(input logic [MULOP_LEN-1:0] op);
    return (op == MULOP_MULH) || (op == MULOP_MULHSU) || (op == MULOP_DIV) || (op == MULOP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [MULOP_LEN-1:0] op);
    return (op == MULOP_MULH) || (op == MULOP_DIV) || (op == MULOP_REM);
  endfunction

  // Only MULW/DIVW/DIVUW/REMW/REMUW exist; the word bit is ignored elsewhere.
  function automatic logic op_w_legal(input logic [MULOP_LEN-1:0] op);
    return (op == MULOP_MUL) || op_is_div(op);
  endfunction

endpackage

// File: rtl/exu_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   kill_i         abandon the current division
//   start_i        load operands and begin
//   word_i         32-bit operation width (else XLEN)
//   dividend_i     unsigned dividend (upper bits zero when word_i)
//   divisor_i      unsigned non-zero divisor
//   done_o         high during the final iteration cycle
//   quot_o, rem_o  values after the current iteration; final when done_o
module exu_div_core
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] q_q, r_q, d_q;
  logic [XLEN:0]   trial;
  logic            q_bit;

  // q_q holds the unconsumed dividend bits MSB-first; quotient bits enter at
  // the bottom. Word ops pre-align the dividend so the same MSB is consumed.
  always_comb begin
    trial  = {r_q, q_q[XLEN-1]} - {1'b0, d_q};
    q_bit  = ~trial[XLEN];
    rem_o  = q_bit ? trial[XLEN-1:0] : {r_q[XLEN-2:0], q_q[XLEN-1]};
    quot_o = {q_q[XLEN-2:0], q_bit};
    done_o = busy_q && (cnt_q == CNT_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= word_i ? CNT_W'(32) : CNT_W'(XLEN);
      q_q    <= word_i ? (dividend_i << 32) : dividend_i;
      r_q    <= '0;
      d_q    <= divisor_i;
    end else if (busy_q) begin
      q_q   <= quot_o;
      r_q   <= rem_o;
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exu_muldiv.sv
// Multi-cycle RV64M mul/div unit beside the execute-stage ALU.
// Holds the pipeline via stall_req_o until the result is consumed.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             kill the in-flight op
//   valid_i / ready_o   op handshake (ready only in IDLE)
//   muldiv_op_i, word_i operation code and W variant
//   rs1_data_i, rs2_data_i operands
//   out_valid_o / out_ready_i result handshake, result_o result
//   stall_req_o         pipeline hold request
//
// state   | meaning
// IDLE    | waiting for an op
// CALC    | iterating (shift-add multiply or restoring divide)
// DONE    | result valid, waiting for out_ready_i
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MUL_STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [MULOP_LEN-1:0] muldiv_op_i,
  input  logic                 word_i,
  input  logic [XLEN-1:0]      rs1_data_i,
  input  logic [XLEN-1:0]      rs2_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic                 stall_req_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_X   = XLEN'(1) << (XLEN - 1);

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic sgn);
    return sgn ? XLEN'($signed(x)) : XLEN'(x);
  endfunction

  state_e                state_q, state_d;
  logic [MULOP_LEN-1:0]  op_q;
  logic                  w_q, sa_q, neg_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     mcand_q, prod_q, prod_d, prod_sel;
  logic [XLEN-1:0]       mplier_q, result_q, result_d;

  logic                  accept, is_w, sgn_a, sgn_b, a_neg, b_neg, dbz, ovf, fast;
  logic [XLEN-1:0]       a_ext, b_ext, a_mag, b_mag, min_neg, fast_res;
  logic                  div_done, calc_last;
  logic [XLEN-1:0]       div_quot, div_rem, quot_fix, rem_fix, calc_raw, calc_res;

  assign accept      = valid_i && (state_q == ST_IDLE) && !flush_i;
  assign ready_o     = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign stall_req_o = accept || (state_q == ST_CALC) || ((state_q == ST_DONE) && !out_ready_i);

  // Operand preparation: W extension, magnitude conversion, fast-path detect.
  always_comb begin
    is_w  = word_i && (XLEN == 64) && op_w_legal(muldiv_op_i);
    sgn_a = op_signed_a(muldiv_op_i);
    sgn_b = op_signed_b(muldiv_op_i);
    a_ext = is_w ? ext32(rs1_data_i[31:0], sgn_a) : rs1_data_i;
    b_ext = is_w ? ext32(rs2_data_i[31:0], sgn_b) : rs2_data_i;
    a_neg = sgn_a && a_ext[XLEN-1];
    b_neg = sgn_b && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    min_neg = is_w ? ext32(32'h8000_0000, 1'b1) : MIN_X;
    dbz   = op_is_div(muldiv_op_i) && (b_ext == '0);
    ovf   = op_is_div(muldiv_op_i) && sgn_a && (a_ext == min_neg) && (b_ext == '1);
    fast  = dbz || ovf;
    if (dbz) fast_res = op_is_rem(muldiv_op_i) ? a_ext : '1;
    else     fast_res = op_is_rem(muldiv_op_i) ? '0 : a_ext;
    if (is_w) fast_res = ext32(fast_res[31:0], 1'b1);
  end

  exu_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .kill_i     (flush_i),
    .start_i    (accept && op_is_div(muldiv_op_i) && !fast),
    .word_i     (is_w),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // One multiplier step plus the sign fix-up of whichever result finishes now.
  always_comb begin
    prod_d = prod_q;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) prod_d = prod_d + (mcand_q << j);
    end
    prod_sel = neg_q ? -prod_d : prod_d;
    quot_fix = neg_q ? -div_quot : div_quot;
    rem_fix  = sa_q ? -div_rem : div_rem;
    if (op_is_div(op_q))         calc_raw = op_is_rem(op_q) ? rem_fix : quot_fix;
    else if (op_q == MULOP_MUL)  calc_raw = prod_sel[XLEN-1:0];
    else                         calc_raw = prod_sel[2*XLEN-1:XLEN];
    calc_res  = w_q ? ext32(calc_raw[31:0], 1'b1) : calc_raw;
    calc_last = op_is_div(op_q) ? div_done : (cnt_q == CNT_ONE);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fast) begin
            state_d  = ST_DONE;
            result_d = fast_res;
          end else begin
            state_d = ST_CALC;
            if (op_is_div(muldiv_op_i)) cnt_d = is_w ? CNT_W'(32) : CNT_W'(XLEN);
            else cnt_d = is_w ? CNT_W'(32 / MUL_STEP) : CNT_W'(XLEN / MUL_STEP);
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (calc_last) begin
          state_d  = ST_DONE;
          result_d = calc_res;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      w_q      <= 1'b0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (accept) begin
        op_q     <= muldiv_op_i;
        w_q      <= is_w;
        sa_q     <= a_neg;
        neg_q    <= a_neg ^ b_neg;
        mcand_q  <= {{XLEN{1'b0}}, a_mag};
        mplier_q <= b_mag;
        prod_q   <= '0;
      end else if (state_q == ST_CALC) begin
        prod_q   <= prod_d;
        mcand_q  <= mcand_q << MUL_STEP;
        mplier_q <= mplier_q >> MUL_STEP;
      end
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
module tb_exu_muldiv;
  import exu_muldiv_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, flush_i, valid_i, word_i, out_ready_i;
  logic [MULOP_LEN-1:0] muldiv_op_i;
  logic [63:0]          rs1_data_i, rs2_data_i, result_o;
  logic                 ready_o, out_valid_o, stall_req_o;

  int errors = 0;
  int checks = 0;

  exu_muldiv #(.XLEN(64), .MUL_STEP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .muldiv_op_i (muldiv_op_i),
    .word_i      (word_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    muldiv_op_i = op;
    word_i      = w;
    rs1_data_i  = a;
    rs2_data_i  = b;
    valid_i     = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    int          lat;
    logic        stall_ok, hold_ok, seen;
    logic [63:0] res;
    stall_ok = 1'b1;
    hold_ok  = 1'b1;
    seen     = 1'b0;
    lat      = 0;
    @(negedge clk);
    muldiv_op_i = op;
    word_i      = w;
    rs1_data_i  = a;
    rs2_data_i  = b;
    valid_i     = 1'b1;
    #1 if (!stall_req_o) stall_ok = 1'b0;
    @(posedge clk);
    #1 valid_i = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!stall_req_o) stall_ok = 1'b0;
      seen = out_valid_o;
    end
    check({tag, " out_valid"}, {63'd0, out_valid_o}, 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    res = result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result_o !== res || !stall_req_o || !out_valid_o) hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, " hold stable"}, {63'd0, hold_ok}, 64'd1);
    check({tag, " stall held"}, {63'd0, stall_ok}, 64'd1);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1 out_ready_i = 1'b0;
    @(negedge clk);
    check({tag, " back idle"}, {62'd0, ready_o, out_valid_o}, 64'd2);
  endtask

  initial begin
    logic vld_seen;
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; word_i = 1'b0; out_ready_i = 1'b0;
    muldiv_op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", {63'd0, ready_o}, 64'd1);
    check("reset out_valid", {63'd0, out_valid_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", {63'd0, stall_req_o}, 64'd0);

    run_op("MUL", MULOP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, 0);
    run_op("MULHU", MULOP_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("MULHSU", MULOP_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("DIV", MULOP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 0);
    run_op("REM", MULOP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("DIVU", MULOP_DIVU, 1'b0, 64'd20, 64'd3, 64'd6, 65, 0);
    run_op("DIV by0", MULOP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("REM by0", MULOP_REM, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("DIV ovf", MULOP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("REM ovf", MULOP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("DIVW ovf", MULOP_DIV, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("MULW", MULOP_MUL, 1'b1, 64'h8000_0000, 64'd2, 64'd0, 17, 0);
    run_op("REMUW", MULOP_REMU, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'hF, 33, 0);
    run_op("DIVW", MULOP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);

    // Flush in the tenth CALC cycle of a divide.
    issue(MULOP_DIV, 1'b0, 64'd1000, 64'd7);
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush calc ready", {63'd0, ready_o}, 64'd1);
    check("flush calc stall", {63'd0, stall_req_o}, 64'd0);
    check("flush calc result kept", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
    vld_seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid_o) vld_seen = 1'b1;
    end
    check("flush calc no valid", {63'd0, vld_seen}, 64'd0);

    // Result held while the consumer stalls for 5 cycles.
    run_op("MUL hold", MULOP_MUL, 1'b0, 64'd3, 64'd5, 64'd15, 33, 5);

    // Flush while in DONE drops the result.
    issue(MULOP_DIVU, 1'b0, 64'd9, 64'd0);
    @(negedge clk);
    check("flush done valid before", {63'd0, out_valid_o}, 64'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush done dropped", {62'd0, ready_o, out_valid_o}, 64'd2);

    // Reset in the middle of a multiply.
    issue(MULOP_MULHU, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid ready", {63'd0, ready_o}, 64'd1);
    check("rst mid out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst mid result", result_o, 64'd0);
    check("rst mid stall", {63'd0, stall_req_o}, 64'd0);

    run_op("DIVU after rst", MULOP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
